// File: rtl/hamming_rx_unpacker_pkg.sv
// Shared types and helpers for the Hamming(7,4) receive unpacker.
package hamming_rx_unpacker_pkg;

  localparam int CW_W  = 7;
  localparam int MSG_W = 4;

  // Codeword position p sits at rx[p-1]; data lives at positions 3,5,6,7.
  localparam int D0_POS = 2;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  typedef struct packed {
    logic             err;
    logic [MSG_W-1:0] msg;
  } fifo_entry_t;

  function automatic logic [MSG_W-1:0] extract_msg(input logic [CW_W-1:0] cw);
    return {cw[D3_POS], cw[D2_POS], cw[D1_POS], cw[D0_POS]};
  endfunction

endpackage

// File: rtl/hamming_rx_unpacker_if.sv
// Decoder-facing capture inputs and consumer-facing valid/ready output of the unpacker.
interface hamming_rx_unpacker_if;
  import hamming_rx_unpacker_pkg::*;

  logic             rx_valid;
  logic [CW_W-1:0]  rx;
  logic             error_det;
  logic             out_ready;
  logic             out_valid;
  logic [MSG_W-1:0] out_data;
  logic             out_err;

  modport master (
    output rx_valid, rx, error_det, out_ready,
    input  out_valid, out_data, out_err
  );

  modport slave (
    input  rx_valid, rx, error_det, out_ready,
    output out_valid, out_data, out_err
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered storage and read from the head register.
// Latency: a push in cycle N is visible at pop_dat in cycle N+1.
// Backpressure: push is refused when full unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = count;
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/hamming_rx_unpacker.sv
// Captures one decoded Hamming(7,4) codeword per frame, queues {err,msg}, keeps link statistics.
// Latency: word captured in cycle N appears on out_* in cycle N+1 at the earliest.
// Backpressure: out_ready stalls the FIFO head; a capture into a full FIFO without a pop is dropped.
module hamming_rx_unpacker
  import hamming_rx_unpacker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  hamming_rx_unpacker_if.slave   bus,
  input  logic                   clear_stats,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       words_rcvd,
  output logic [CNT_W-1:0]       errs_rcvd,
  output logic [CNT_W-1:0]       drops
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic        rx_valid_d;
  logic        capture;
  logic        pop;
  logic        drop;
  logic        full;
  logic        empty;
  fifo_entry_t in_entry;
  fifo_entry_t head_entry;

  // Resetting to 1 keeps a rx_valid held high across reset from looking like a new frame.
  always_ff @(posedge clk) begin
    if (reset) rx_valid_d <= 1'b1;
    else       rx_valid_d <= bus.rx_valid;
  end

  always_comb begin
    in_entry     = '0;
    in_entry.err = bus.error_det;
    in_entry.msg = extract_msg(bus.rx);
  end

  assign capture = bus.rx_valid & ~rx_valid_d;
  assign pop     = bus.out_valid & bus.out_ready;
  assign drop    = capture & full & ~pop;

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (capture),
    .push_dat (in_entry),
    .pop      (pop),
    .pop_dat  (head_entry),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : head_entry.msg;
  assign bus.out_err   = ~empty & head_entry.err;

  // A clear in the same cycle as an event discards that event.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      words_rcvd <= '0;
      errs_rcvd  <= '0;
      drops      <= '0;
      overflow   <= 1'b0;
    end else begin
      if (capture)                 words_rcvd <= sat_inc(words_rcvd);
      if (capture & bus.error_det) errs_rcvd  <= sat_inc(errs_rcvd);
      if (drop) begin
        drops    <= sat_inc(drops);
        overflow <= 1'b1;
      end
    end
  end

endmodule
